// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment scan driver.
package seg_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   typedef logic [1:0] dig_idx_t;

   typedef enum logic {BLANK, ON} phase_t;

   typedef struct packed {
      logic [3:0] min1;
      logic [3:0] min0;
      logic [3:0] sec1;
      logic [3:0] sec0;
   } frame_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_DASH;
      case (bcd)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with blanking gap, blink and decimal points.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on the two minute digits.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 27000,
   parameter int unsigned BLANK_CYC = 270,
   parameter int unsigned BLINK_DIV = 6750000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] sec0,
   input  logic [3:0] sec1,
   input  logic [3:0] min0,
   input  logic [3:0] min1,
   input  logic [3:0] blink_mask,
   input  logic [3:0] dp_mask,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [3:0] an_n,
   output logic       frame_start
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned BW = $clog2(BLINK_DIV);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [CW-1:0] slot_cnt_q, slot_cnt_d;
   dig_idx_t      dig_q, dig_d;
   phase_t        phase_q, phase_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   frame_t        frame_q, frame_d;
   logic [3:0]    dp_lat_q, dp_lat_d;
   logic [3:0]    an_n_q, an_n_d;
   logic [6:0]    seg_n_q, seg_n_d;
   logic          dp_n_q, dp_n_d;
   logic          frame_start_q, frame_start_d;
   logic          slot_wrap, frame_load, show;
   logic [3:0]    cur_bcd;
   logic [6:0]    cur_seg;

   // Counters and the frame snapshot taken as the scan wraps back into digit 0
   always_comb begin
      slot_wrap   = (slot_cnt_q == SLOT_LAST);
      frame_load  = slot_wrap && (dig_q == 2'd3);
      slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + CW'(1);
      dig_d       = slot_wrap ? dig_q + 2'd1 : dig_q;
      frame_d     = frame_load ? '{min1: min1, min0: min0, sec1: sec1, sec0: sec0} : frame_q;
      dp_lat_d    = frame_load ? dp_mask : dp_lat_q;
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
      blink_on_d  = (blink_cnt_q == BLINK_LAST) ? ~blink_on_q : blink_on_q;
   end

   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         BLANK:   if (slot_cnt_d == BLANK_END) phase_d = ON;
         ON:      if (slot_wrap) phase_d = BLANK;
         default: phase_d = BLANK;
      endcase
   end

   always_comb begin
      cur_bcd = frame_d.sec0;
      case (dig_d)
         2'd0:    cur_bcd = frame_d.sec0;
         2'd1:    cur_bcd = frame_d.sec1;
         2'd2:    cur_bcd = frame_d.min0;
         default: cur_bcd = frame_d.min1;
      endcase
   end

   bcd_to_seg u_dec (
      .bcd   (cur_bcd),
      .seg_n (cur_seg)
   );

   // Outputs are decoded from next-state values so the pins line up with the counters
   always_comb begin
      show = (phase_d == ON) && !(blink_mask[dig_d] && !blink_on_d);
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_d == 2'd3 && frame_d.min1 == 4'd0) show = 1'b0;
      if (dig_d == 2'd2 && frame_d.min1 == 4'd0 && frame_d.min0 == 4'd0) show = 1'b0;
`endif
      an_n_d        = 4'hF;
      seg_n_d       = SEG_OFF;
      dp_n_d        = 1'b1;
      frame_start_d = frame_load;
      if (show) begin
         an_n_d[dig_d] = 1'b0;
         seg_n_d       = cur_seg;
         dp_n_d        = ~dp_lat_d[dig_d];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_cnt_q    <= '0;
         dig_q         <= '0;
         phase_q       <= BLANK;
         blink_cnt_q   <= '0;
         blink_on_q    <= 1'b1;
         frame_q       <= '0;
         dp_lat_q      <= '0;
         an_n_q        <= 4'hF;
         seg_n_q       <= SEG_OFF;
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         dig_q         <= dig_d;
         phase_q       <= phase_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_on_q    <= blink_on_d;
         frame_q       <= frame_d;
         dp_lat_q      <= dp_lat_d;
         an_n_q        <= an_n_d;
         seg_n_q       <= seg_n_d;
         dp_n_q        <= dp_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign an_n        = an_n_q;
   assign seg_n       = seg_n_q;
   assign dp_n        = dp_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64.
module tb_seg_scan_driver;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] sec0, sec1, min0, min1;
   logic [3:0] blink_mask, dp_mask;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [3:0] an_n;
   logic       frame_start;

   int vec    = 0;
   int miscmp = 0;

   seg_scan_driver #(
      .SCAN_DIV  (8),
      .BLANK_CYC (2),
      .BLINK_DIV (64)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .sec0        (sec0),
      .sec1        (sec1),
      .min0        (min0),
      .min1        (min1),
      .blink_mask  (blink_mask),
      .dp_mask     (dp_mask),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      vec++;
      assert (act === exp) else begin
         miscmp++;
         $error("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " an_n"},        8'(an_n),        8'h0F);
      chk({tag, " seg_n"},       8'(seg_n),       8'h7F);
      chk({tag, " dp_n"},        8'(dp_n),        8'h01);
      chk({tag, " frame_start"}, 8'(frame_start), 8'h00);
   endtask

   // Advance until frame_start (bounded) and compare the cycle count
   task automatic wait_frame(input string tag, input int exp_n);
      int n;
      n = 0;
      while (frame_start !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, " frame_start delay"}, 8'(n), 8'(exp_n));
   endtask

   // Check one 32-cycle frame starting at its frame_start cycle
   task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] show, input logic [3:0] dp, input int mid_sec0);
      logic [6:0] segs [4];
      segs = '{s0, s1, s2, s3};
      for (int i = 0; i < 32; i++) begin
         int d;
         int s;
         logic on;
         logic [3:0] e_an;
         logic [6:0] e_seg;
         logic e_dp;
         d = i / 8;
         s = i % 8;
         on = (s >= 2) && show[d];
         e_an = 4'hF;
         e_seg = 7'h7F;
         e_dp = 1'b1;
         if (on) begin
            e_an[d] = 1'b0;
            e_seg = segs[d];
            e_dp = ~dp[d];
         end
         chk($sformatf("%s an_n d%0d s%0d", tag, d, s),  8'(an_n),  8'(e_an));
         chk($sformatf("%s seg_n d%0d s%0d", tag, d, s), 8'(seg_n), 8'(e_seg));
         chk($sformatf("%s dp_n d%0d s%0d", tag, d, s),  8'(dp_n),  8'(e_dp));
         chk($sformatf("%s frame_start d%0d s%0d", tag, d, s), 8'(frame_start), 8'(i == 0));
         if (mid_sec0 >= 0 && i == 12) sec0 = 4'(mid_sec0);
         step();
      end
   endtask

   initial begin
      rstn       = 1'b0;
      sec0       = 4'd1;
      sec1       = 4'd2;
      min0       = 4'd3;
      min1       = 4'd4;
      blink_mask = 4'b0000;
      dp_mask    = 4'b0000;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");

      rstn = 1'b1;
      wait_frame("first", 32);
      // No tearing: a change after the snapshot waits for the next frame
      sec0 = 4'd5;
      check_frame("digits1234", 7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 4'h0, -1);
      check_frame("sec0_5", 7'h12, 7'h24, 7'h30, 7'h19, 4'hF, 4'h0, 6);
      sec1    = 4'hC;
      dp_mask = 4'b0100;
      check_frame("sec0_6", 7'h02, 7'h24, 7'h30, 7'h19, 4'hF, 4'h0, -1);
      check_frame("dash_dp", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hF, 4'b0100, -1);

      // Blink on digit 0: blink_on is 1 for 64 cycles then 0 for 64 from reset release
      blink_mask = 4'b0001;
      check_frame("blink_on_a", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hF, 4'b0100, -1);
      check_frame("blink_off_a", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hE, 4'b0100, -1);
      check_frame("blink_off_b", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hE, 4'b0100, -1);
      check_frame("blink_on_b", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hF, 4'b0100, -1);
      check_frame("blink_on_c", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hF, 4'b0100, -1);
      check_frame("blink_off_c", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hE, 4'b0100, -1);

      blink_mask = 4'b0000;
      min1       = 4'd0;
      min0       = 4'd0;
      sec1       = 4'd3;
      sec0       = 4'd7;
      dp_mask    = 4'b0000;
      check_frame("pre_lz", 7'h02, 7'h3F, 7'h30, 7'h19, 4'hF, 4'b0100, -1);
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("lz_0037", 7'h78, 7'h30, 7'h40, 7'h40, 4'b0011, 4'h0, -1);
`else
      check_frame("lz_0037", 7'h78, 7'h30, 7'h40, 7'h40, 4'b1111, 4'h0, -1);
`endif

      // Asynchronous reset in the middle of digit 0's ON phase
      repeat (3) step();
      chk("pre_reset an_n",  8'(an_n),  8'h0E);
      chk("pre_reset seg_n", 8'(seg_n), 8'h78);
      #2 rstn = 1'b0;
      #1 chk_reset_outputs("async_reset");
      @(negedge clk);
      chk_reset_outputs("held_reset");
      rstn = 1'b1;
      wait_frame("after_reset", 32);
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("post_reset", 7'h78, 7'h30, 7'h40, 7'h40, 4'b0011, 4'h0, -1);
`else
      check_frame("post_reset", 7'h78, 7'h30, 7'h40, 7'h40, 4'b1111, 4'h0, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
